// File: rtl/rinsc_pkg.sv
// Shared types and constants for the RINSC pipeline interlock logic.
package rinsc_pkg;

   // Register-file address width (32-entry RF).
   localparam int REG_AW = 5;

   // Stages between ID and RF-write commit: EX, MEM, WB.
   localparam int SB_DEPTH = 3;

   // Scoreboard slot names, youngest first.
   localparam int SB_EX  = 0;
   localparam int SB_MEM = 1;
   localparam int SB_WB  = 2;

   // One in-flight register writer.
   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
   } sb_entry_t;

   // Controller mode. FLUSH is the cycle that squashes the fall-through fetch.
   typedef enum logic [1:0] {
      ST_RUN   = 2'd0,
      ST_STALL = 2'd1,
      ST_FLUSH = 2'd2
   } ctrl_state_e;

endpackage

// File: rtl/hazard_scoreboard.sv
// Shift-register scoreboard of in-flight RF writers with two compare ports.
// Every entry advances one stage per cycle; the WB entry still hazards
// because the RF write lands on the edge that ends WB.
module hazard_scoreboard
   import rinsc_pkg::*;
#(
   parameter int SB_DEPTH = rinsc_pkg::SB_DEPTH
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              push_valid_i,
   input  logic [REG_AW-1:0] push_rd_i,
   input  logic [REG_AW-1:0] ra_i,
   input  logic [REG_AW-1:0] rb_i,
   output logic              match_a_o,
   output logic              match_b_o
);

   sb_entry_t sb_q [SB_DEPTH];
   sb_entry_t sb_d [SB_DEPTH];

   // Next contents: new writer enters EX, everything else moves one stage on.
   always_comb begin
      sb_d[SB_EX].valid = push_valid_i;
      sb_d[SB_EX].rd    = push_rd_i;
      for (int i = 1; i < SB_DEPTH; i++) begin
         sb_d[i] = sb_q[i-1];
      end
   end

   // Scoreboard register; reset forgets every tracked writer.
   // NOTE: reset clears the rd fields too, not only valid; rd is a don't-care
   // once valid is 0, but a defined value keeps the compare path X-free.
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < SB_DEPTH; i++) begin
            sb_q[i] <= '0;
         end
      end else begin
         for (int i = 0; i < SB_DEPTH; i++) begin
            sb_q[i] <= sb_d[i];
         end
      end
   end

   // Dual-port compare against every live entry; r0 is not exempt.
   // NOTE: both outputs get a default before the loop so no latch is inferred.
   always_comb begin
      match_a_o = 1'b0;
      match_b_o = 1'b0;
      for (int i = 0; i < SB_DEPTH; i++) begin
         if (sb_q[i].valid && (sb_q[i].rd == ra_i)) match_a_o = 1'b1;
         if (sb_q[i].valid && (sb_q[i].rd == rb_i)) match_b_o = 1'b1;
      end
   end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Interlock controller for the 5-stage RINSC pipeline without forwarding.
// Stalls IF/ID and bubbles ID/EX on RAW hazards, squashes the wrong-path
// fetch after a taken jump, and keeps saturating stall/flush counters.
module pipeline_hazard_ctrl
   import rinsc_pkg::*;
#(
   parameter int SB_DEPTH = rinsc_pkg::SB_DEPTH,
   parameter int CNT_W    = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic [REG_AW-1:0] id_ra,
   input  logic [REG_AW-1:0] id_rb,
   input  logic              id_use_ra,
   input  logic              id_use_rb,
   input  logic [REG_AW-1:0] id_rd,
   input  logic              id_regwrite,
   input  logic              id_jump,
   output logic              pc_hold,
   output logic              ifid_hold,
   output logic              idex_bubble,
   output logic              pc_jump_en,
   output logic              id_kill,
   output logic [CNT_W-1:0]  stall_cnt,
   output logic [CNT_W-1:0]  flush_cnt
);

   localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};
   localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

   ctrl_state_e      state_q, state_d;
   logic             match_a, match_b;
   logic             hazard;
   logic             stall;
   logic             sb_push;
   logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
   logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

   // A squashed or stalled ID slot never becomes a tracked writer.
   assign sb_push = id_regwrite & ~stall & ~id_kill;

   hazard_scoreboard #(
      .SB_DEPTH (SB_DEPTH)
   ) u_scoreboard (
      .clk          (clk),
      .reset        (reset),
      .push_valid_i (sb_push),
      .push_rd_i    (id_rd),
      .ra_i         (id_ra),
      .rb_i         (id_rb),
      .match_a_o    (match_a),
      .match_b_o    (match_b)
   );

   assign hazard  = (id_use_ra & match_a) | (id_use_rb & match_b);
   assign id_kill = (state_q == ST_FLUSH);

   // Mode register; reset drops any pending squash and returns to RUN.
   // NOTE: sequential state uses non-blocking assignments only, so every
   // register samples pre-edge values regardless of block ordering.
   always_ff @(posedge clk) begin
      if (reset) begin
         state_q <= ST_RUN;
      end else begin
         state_q <= state_d;
      end
   end

   // Next mode and pipeline control outputs for the instruction now in ID.
   always_comb begin
      state_d     = ST_RUN;
      stall       = 1'b0;
      pc_hold     = 1'b0;
      ifid_hold   = 1'b0;
      idex_bubble = 1'b0;
      pc_jump_en  = 1'b0;
      case (state_q)
         ST_FLUSH: begin
            // The IfId content is the fall-through fetch: drop it, no hazard check.
            idex_bubble = 1'b1;
         end
         default: begin
            stall       = hazard;
            pc_hold     = hazard;
            ifid_hold   = hazard;
            idex_bubble = hazard;
            // A jump held by a stall waits in ID until its operands are ready.
            pc_jump_en  = id_jump & ~hazard;
         end
      endcase
      if (pc_jump_en) begin
         state_d = ST_FLUSH;
      end else if (stall) begin
         state_d = ST_STALL;
      end
   end

   // Saturating increments for the two performance counters.
   always_comb begin
      stall_cnt_d = stall_cnt_q;
      flush_cnt_d = flush_cnt_q;
      if (stall && (stall_cnt_q != CNT_MAX)) stall_cnt_d = stall_cnt_q + CNT_ONE;
      if (pc_jump_en && (flush_cnt_q != CNT_MAX)) flush_cnt_d = flush_cnt_q + CNT_ONE;
   end

   // Counter registers.
   always_ff @(posedge clk) begin
      if (reset) begin
         stall_cnt_q <= '0;
         flush_cnt_q <= '0;
      end else begin
         stall_cnt_q <= stall_cnt_d;
         flush_cnt_q <= flush_cnt_d;
      end
   end

   assign stall_cnt = stall_cnt_q;
   assign flush_cnt = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: a reference model pushes the
// expected outputs of every cycle into a queue as stimulus is driven, and the
// entry is popped and compared when the DUT outputs settle mid-cycle.
// A second instance with 4-bit counters exercises counter saturation.
module tb_pipeline_hazard_ctrl;
   import rinsc_pkg::*;

   localparam int MAIN_MAX  = 65535;
   localparam int SMALL_MAX = 15;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic              reset;
   logic [REG_AW-1:0] id_ra, id_rb, id_rd;
   logic              id_use_ra, id_use_rb, id_regwrite, id_jump;

   logic        pc_hold, ifid_hold, idex_bubble, pc_jump_en, id_kill;
   logic [15:0] stall_cnt, flush_cnt;
   logic        s_pc_hold, s_ifid_hold, s_idex_bubble, s_pc_jump_en, s_id_kill;
   logic [3:0]  s_stall_cnt, s_flush_cnt;

   pipeline_hazard_ctrl #(.SB_DEPTH(3), .CNT_W(16)) u_dut (
      .clk(clk), .reset(reset),
      .id_ra(id_ra), .id_rb(id_rb), .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_jump(id_jump),
      .pc_hold(pc_hold), .ifid_hold(ifid_hold), .idex_bubble(idex_bubble),
      .pc_jump_en(pc_jump_en), .id_kill(id_kill),
      .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
   );

   pipeline_hazard_ctrl #(.SB_DEPTH(3), .CNT_W(4)) u_dut_small (
      .clk(clk), .reset(reset),
      .id_ra(id_ra), .id_rb(id_rb), .id_use_ra(id_use_ra), .id_use_rb(id_use_rb),
      .id_rd(id_rd), .id_regwrite(id_regwrite), .id_jump(id_jump),
      .pc_hold(s_pc_hold), .ifid_hold(s_ifid_hold), .idex_bubble(s_idex_bubble),
      .pc_jump_en(s_pc_jump_en), .id_kill(s_id_kill),
      .stall_cnt(s_stall_cnt), .flush_cnt(s_flush_cnt)
   );

   typedef struct packed {
      logic        pc_hold;
      logic        ifid_hold;
      logic        idex_bubble;
      logic        pc_jump_en;
      logic        id_kill;
      logic [15:0] stall_cnt;
      logic [15:0] flush_cnt;
      logic [3:0]  s_stall_cnt;
      logic [3:0]  s_flush_cnt;
   } exp_t;

   exp_t exp_q[$];

   int vectors     = 0;
   int miscompares = 0;

   // Reference model state: scoreboard, pending squash, counters.
   logic              m_v  [3];
   logic [REG_AW-1:0] m_rd [3];
   logic              m_kill;
   int                m_scnt, m_fcnt, m_sscnt, m_sfcnt;

   // Outputs observed in the most recent cycle, for directed checks.
   logic last_stall, last_jen, last_kill, last_bubble;
   int   last_scnt, last_fcnt, last_sscnt, last_sfcnt;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      vectors++;
      if (got !== exp) begin
         miscompares++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", tag, got, exp, $time);
      end
   endtask

   // One pipeline cycle: drive ID fields, predict, compare at negedge, advance model.
   task automatic cycle(input logic rst, input logic ura, input logic [REG_AW-1:0] ra,
                        input logic urb, input logic [REG_AW-1:0] rb, input logic rw,
                        input logic [REG_AW-1:0] rd, input logic jmp, input bit chk);
      exp_t e;
      exp_t got;
      logic hz, st, jen;
      reset = rst; id_use_ra = ura; id_ra = ra; id_use_rb = urb; id_rb = rb;
      id_regwrite = rw; id_rd = rd; id_jump = jmp;

      hz = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (m_v[i] && ura && (m_rd[i] == ra)) hz = 1'b1;
         if (m_v[i] && urb && (m_rd[i] == rb)) hz = 1'b1;
      end
      st  = ~m_kill & hz;
      jen = ~m_kill & ~st & jmp;
      e.pc_hold     = st;
      e.ifid_hold   = st;
      e.idex_bubble = st | m_kill;
      e.pc_jump_en  = jen;
      e.id_kill     = m_kill;
      e.stall_cnt   = 16'(m_scnt);
      e.flush_cnt   = 16'(m_fcnt);
      e.s_stall_cnt = 4'(m_sscnt);
      e.s_flush_cnt = 4'(m_sfcnt);
      exp_q.push_back(e);

      @(negedge clk);
      if (exp_q.size() == 0) begin
         check("queue_underflow", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         if (chk) begin
            check("pc_hold",     {31'd0, pc_hold},       {31'd0, e.pc_hold});
            check("ifid_hold",   {31'd0, ifid_hold},     {31'd0, e.ifid_hold});
            check("idex_bubble", {31'd0, idex_bubble},   {31'd0, e.idex_bubble});
            check("pc_jump_en",  {31'd0, pc_jump_en},    {31'd0, e.pc_jump_en});
            check("id_kill",     {31'd0, id_kill},       {31'd0, e.id_kill});
            check("stall_cnt",   {16'd0, stall_cnt},     {16'd0, e.stall_cnt});
            check("flush_cnt",   {16'd0, flush_cnt},     {16'd0, e.flush_cnt});
            check("s_stall_cnt", {28'd0, s_stall_cnt},   {28'd0, e.s_stall_cnt});
            check("s_flush_cnt", {28'd0, s_flush_cnt},   {28'd0, e.s_flush_cnt});
            check("s_pc_hold",   {31'd0, s_pc_hold},     {31'd0, e.pc_hold});
         end
      end
      got.pc_hold = pc_hold;
      last_stall  = pc_hold;
      last_jen    = pc_jump_en;
      last_kill   = id_kill;
      last_bubble = idex_bubble;
      last_scnt   = int'(stall_cnt);
      last_fcnt   = int'(flush_cnt);
      last_sscnt  = int'(s_stall_cnt);
      last_sfcnt  = int'(s_flush_cnt);

      if (rst) begin
         for (int i = 0; i < 3; i++) begin
            m_v[i]  = 1'b0;
            m_rd[i] = '0;
         end
         m_kill = 1'b0; m_scnt = 0; m_fcnt = 0; m_sscnt = 0; m_sfcnt = 0;
      end else begin
         m_v[2] = m_v[1]; m_rd[2] = m_rd[1];
         m_v[1] = m_v[0]; m_rd[1] = m_rd[0];
         m_v[0] = rw & ~st & ~m_kill; m_rd[0] = rd;
         if (st && m_scnt < MAIN_MAX)   m_scnt++;
         if (st && m_sscnt < SMALL_MAX) m_sscnt++;
         if (jen && m_fcnt < MAIN_MAX)   m_fcnt++;
         if (jen && m_sfcnt < SMALL_MAX) m_sfcnt++;
         m_kill = jen;
      end
      @(posedge clk);
      #1;
   endtask

   task automatic op(input logic ura, input logic [REG_AW-1:0] ra, input logic urb,
                     input logic [REG_AW-1:0] rb, input logic rw,
                     input logic [REG_AW-1:0] rd, input logic jmp);
      cycle(1'b0, ura, ra, urb, rb, rw, rd, jmp, 1'b1);
   endtask

   task automatic nop();
      op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
   endtask

   // Present one instruction until it leaves ID; returns the number of stalled cycles.
   task automatic hold_until_issue(input logic ura, input logic [REG_AW-1:0] ra,
                                   input logic urb, input logic [REG_AW-1:0] rb,
                                   input logic jmp, output int n_stall);
      n_stall = 0;
      for (int k = 0; k < 8; k++) begin
         op(ura, ra, urb, rb, 1'b0, 5'd0, jmp);
         if (!last_stall) break;
         n_stall++;
      end
      if (last_stall) check("issue_timeout", 32'd1, 32'd0);
   endtask

   initial begin
      int n;
      for (int i = 0; i < 3; i++) begin
         m_v[i]  = 1'b0;
         m_rd[i] = '0;
      end
      m_kill = 1'b0; m_scnt = 0; m_fcnt = 0; m_sscnt = 0; m_sfcnt = 0;
      reset = 1'b1; id_ra = '0; id_rb = '0; id_rd = '0;
      id_use_ra = 1'b0; id_use_rb = 1'b0; id_regwrite = 1'b0; id_jump = 1'b0;
      #1;

      // Reset for two cycles while ID reads r3: no stall, counters clear.
      cycle(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0);
      cycle(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      check("rst_stall", {31'd0, last_stall}, 32'd0);
      check("rst_kill",  {31'd0, last_kill},  32'd0);
      check("rst_scnt",  last_scnt, 32'd0);

      // ADD r5, then a reader of r5 on ra: 3 stall cycles, issues on the 4th.
      op(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
      hold_until_issue(1'b1, 5'd5, 1'b0, 5'd0, 1'b0, n);
      check("raw_ex_len",  n, 32'd3);
      check("raw_ex_scnt", last_scnt, 32'd3);
      repeat (3) nop();

      // Writer r7, one independent instruction, then a reader of r7 on rb: 2 stalls.
      op(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd7, 1'b0);
      op(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd9, 1'b0);
      hold_until_issue(1'b0, 5'd0, 1'b1, 5'd7, 1'b0, n);
      check("raw_mem_len", n, 32'd2);
      repeat (3) nop();

      // Hazard-free jump with link write to r31, then its squashed fall-through.
      op(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd31, 1'b1);
      check("jmp_en", {31'd0, last_jen}, 32'd1);
      op(1'b1, 5'd31, 1'b0, 5'd0, 1'b1, 5'd12, 1'b1);
      check("kill_flag",   {31'd0, last_kill},   32'd1);
      check("kill_bubble", {31'd0, last_bubble}, 32'd1);
      check("kill_no_jmp", {31'd0, last_jen},    32'd0);
      check("kill_fcnt",   last_fcnt, 32'd1);
      op(1'b1, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      check("killed_not_tracked", {31'd0, last_stall}, 32'd0);
      repeat (3) nop();

      // Jump reading r2 while r2 sits in MEM: held 2 cycles, then accepted.
      op(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd2, 1'b0);
      nop();
      hold_until_issue(1'b1, 5'd2, 1'b0, 5'd0, 1'b1, n);
      check("jmp_hold_len", n, 32'd2);
      check("jmp_hold_en",  {31'd0, last_jen}, 32'd1);
      nop();
      check("jmp_hold_kill", {31'd0, last_kill}, 32'd1);
      repeat (3) nop();

      // Reset asserted mid-stall: the following cycle no longer stalls.
      op(1'b0, 5'd0, 1'b0, 5'd0, 1'b1, 5'd4, 1'b0);
      op(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      check("pre_rst_stall", {31'd0, last_stall}, 32'd1);
      cycle(1'b1, 1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1);
      op(1'b1, 5'd4, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0);
      check("post_rst_stall", {31'd0, last_stall}, 32'd0);
      check("post_rst_scnt",  last_scnt, 32'd0);

      // Randomised traffic over a small register range to provoke overlaps.
      for (int k = 0; k < 400; k++) begin
         cycle(($urandom_range(0, 49) == 0),
               1'($urandom), 5'($urandom_range(0, 3)),
               1'($urandom), 5'($urandom_range(0, 3)),
               1'($urandom), 5'($urandom_range(0, 3)),
               ($urandom_range(0, 5) == 0), 1'b1);
      end

      // Back-to-back self-dependent writers and repeated jumps saturate the 4-bit counters.
      repeat (80) op(1'b1, 5'd5, 1'b0, 5'd0, 1'b1, 5'd5, 1'b0);
      repeat (20) begin
         op(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 1'b1);
         nop();
      end
      nop();
      check("sat_small_scnt", last_sscnt, 32'd15);
      check("sat_small_fcnt", last_sfcnt, 32'd15);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
